// File: rtl/conv3d_pkg.sv
// Shared types for the 3D convolution voxel streamer: FSM states, the buffered
// beat format and the default volume geometry.
package conv3d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VOL_D  = 8;
  localparam int VOL_H  = 64;
  localparam int VOL_W  = 64;
  localparam int N      = VOL_D * VOL_H * VOL_W;
  localparam int BEAT_W = 8;

  // Beat data width is fixed here; the streamer's DATA_W must match it.
  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              last;
  } beat_t;

  function automatic int vol_size(input int d, input int h, input int w);
    return d * h * w;
  endfunction

endpackage

// File: rtl/conv3d_stream_buf.sv
// Two-entry FIFO of voxel beats sitting between the memory response and the
// stream output; absorbs the read latency while the consumer stalls.
module conv3d_stream_buf
  import conv3d_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_data,
  input  logic       pop,
  output logic [1:0] count,
  output beat_t      head,
  output logic       empty,
  output logic       full
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv3d_voxel_streamer.sv
// Streams one D x H x W volume in raster order (x, then y, then z) from a
// 1-cycle-latency voxel memory into a valid/ready stream with last and done.
module conv3d_voxel_streamer
  import conv3d_pkg::*;
#(
  parameter int D      = VOL_D,
  parameter int H      = VOL_H,
  parameter int W      = VOL_W,
  parameter int DATA_W = BEAT_W,
  parameter int ADDR_W = $clog2(D * H * W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] voxel_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              last_out,
  output logic              busy,
  output logic              done
);

  localparam int NV    = vol_size(D, H, W);
  // One extra bit so the index can sit at NV once the volume is fully read.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NV - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             inflight;
  logic             inflight_last;
  logic [1:0]       count;
  logic [2:0]       occ;
  beat_t            head;
  beat_t            push_beat;
  logic             empty;
  logic             full;
  logic             pop;
  logic             rd_en;

  assign pop       = !empty && ready_in;
  assign occ       = {1'b0, count} + {2'b00, inflight};
  assign push_beat = '{data: mem_rdata, last: inflight_last};

  conv3d_stream_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_beat),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  // Read issue: never let buffered plus in-flight beats exceed two unless one leaves now.
  always_comb begin
    rd_en = 1'b0;
    if ((state == RUN) && (idx < IDX_END) && ((occ < 3'd2) || pop)) begin
      rd_en = 1'b1;
    end else begin
      rd_en = 1'b0;
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? idx[ADDR_W-1:0] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (pop && head.last) state_nxt = DONE;
        else                  state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        idx <= '0;
      end else if (rd_en) begin
        idx <= idx + IDX_W'(1);
      end
      inflight      <= rd_en;
      inflight_last <= rd_en && (idx == IDX_LAST);
    end
  end

  // Buffer storage may hold stale beats after an abort, so gate the head by occupancy.
  assign valid_out = !empty;
  assign voxel_out = empty ? '0 : head.data;
  assign last_out  = !empty && head.last;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_conv3d_voxel_streamer.sv
// Directed bench for conv3d_voxel_streamer on a 2x2x3 volume with a memory
// model returning addr + 0x10.
module tb_conv3d_voxel_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] voxel_out;
  logic       valid_out;
  logic       ready_in;
  logic       last_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int passes = 0;

  int bd[$];
  int bc[$];
  int bl[$];
  int ra[$];
  int rcy[$];
  int dc[$];
  bit [63:0] busy_mask;
  int stab_err;
  int ovf_err;
  int occ_err;
  logic       snap_valid, snap_last, snap_rd, snap_busy, snap_done;
  logic [7:0] snap_voxel;
  logic [3:0] snap_addr;

  always #5 clk = ~clk;

  conv3d_voxel_streamer #(
    .D(2), .H(2), .W(3), .DATA_W(8), .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .voxel_out (voxel_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 8'h10 + {4'h0, mem_addr};
  end

  // mode 0: ready=1; mode 1: ready 1,0,1,0...; mode 2: ready=0 in cycles 2..20.
  task automatic run_cycles(input int ncyc, input int mode, input int s2,
                            input int rc, input int snap_c);
    int occ, infl;
    bit pv, pop;
    logic [7:0] pd;
    logic pl;
    occ = 0; infl = 0; pv = 1'b0; pd = 8'h00; pl = 1'b0;
    bd.delete(); bc.delete(); bl.delete(); ra.delete(); rcy.delete(); dc.delete();
    busy_mask = '0; stab_err = 0; ovf_err = 0; occ_err = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == s2);
      rst   = (c == rc);
      case (mode)
        1:       ready_in = (c % 2 == 0);
        2:       ready_in = !(c >= 2 && c <= 20);
        default: ready_in = 1'b1;
      endcase
      @(negedge clk);
      pop = valid_out && ready_in;
      if (pop) begin
        bd.push_back(int'(voxel_out)); bc.push_back(c); bl.push_back(int'(last_out));
      end
      if (mem_rd_en) begin
        ra.push_back(int'(mem_addr)); rcy.push_back(c);
      end
      if (done) dc.push_back(c);
      if (c < 64) busy_mask[c] = busy;
      if (c == snap_c) begin
        snap_valid = valid_out; snap_voxel = voxel_out; snap_last = last_out;
        snap_rd = mem_rd_en; snap_addr = mem_addr; snap_busy = busy; snap_done = done;
      end
      if (pv && (!valid_out || voxel_out !== pd || last_out !== pl)) stab_err++;
      if (valid_out !== (occ > 0)) occ_err++;
      if (mem_rd_en && (occ + infl == 2) && !pop) ovf_err++;
      occ  = occ + infl - (pop ? 1 : 0);
      infl = mem_rd_en ? 1 : 0;
      pv = valid_out && !ready_in; pd = voxel_out; pl = last_out;
      if (rst) begin occ = 0; infl = 0; pv = 1'b0; end
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0; ready_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_rd_en, mem_addr, voxel_out, valid_out, last_out, busy, done} !== 17'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {mem_rd_en, mem_addr, voxel_out, valid_out, last_out, busy, done});
    else passes++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({valid_out, busy, mem_rd_en} !== 3'b000)
      $display("FAIL idle_after_reset: got %b expected 000", {valid_out, busy, mem_rd_en});
    else passes++;
  endtask

  task automatic test_free_flow();
    bit [63:0] exp_busy;
    run_cycles(40, 0, -1, -1, -1);
    checks++; if (bd.size() != 12) $display("FAIL ff_beat_count: got %0d expected 12", bd.size());
    else passes++;
    for (int i = 0; i < bd.size(); i++) begin
      checks++; if (bd[i] != 16 + i) $display("FAIL ff_data[%0d]: got %0h expected %0h", i, bd[i], 16 + i);
      else passes++;
      checks++; if (bc[i] != 3 + i) $display("FAIL ff_cycle[%0d]: got %0d expected %0d", i, bc[i], 3 + i);
      else passes++;
      checks++; if (bl[i] != ((i == 11) ? 1 : 0)) $display("FAIL ff_last[%0d]: got %0d", i, bl[i]);
      else passes++;
    end
    checks++; if (rcy.size() < 1 || rcy[0] != 1 || ra[0] != 0)
      $display("FAIL ff_first_read: got %0d reads expected addr 0 in cycle 1", rcy.size());
    else passes++;
    checks++; if (dc.size() != 1 || dc[0] != 15)
      $display("FAIL ff_done: got %0d pulses (first %0d) expected one in cycle 15",
               dc.size(), (dc.size() > 0) ? dc[0] : -1);
    else passes++;
    exp_busy = '0;
    for (int c = 1; c <= 15; c++) exp_busy[c] = 1'b1;
    checks++; if (busy_mask[39:0] !== exp_busy[39:0])
      $display("FAIL ff_busy: got %h expected %h", busy_mask[39:0], exp_busy[39:0]);
    else passes++;
    checks++; if (occ_err != 0) $display("FAIL ff_valid_occ: got %0d errors expected 0", occ_err);
    else passes++;
  endtask

  task automatic test_backpressure();
    run_cycles(45, 1, -1, -1, -1);
    checks++; if (bd.size() != 12) $display("FAIL bp_beat_count: got %0d expected 12", bd.size());
    else passes++;
    for (int i = 0; i < bd.size(); i++) begin
      checks++; if (bd[i] != 16 + i) $display("FAIL bp_data[%0d]: got %0h expected %0h", i, bd[i], 16 + i);
      else passes++;
    end
    checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d errors expected 0", stab_err);
    else passes++;
    checks++; if (ovf_err != 0) $display("FAIL bp_issue_rule: got %0d errors expected 0", ovf_err);
    else passes++;
    checks++; if (dc.size() != 1) $display("FAIL bp_done: got %0d expected 1", dc.size());
    else passes++;
  endtask

  task automatic test_long_stall();
    int early;
    run_cycles(50, 2, -1, -1, 10);
    early = 0;
    foreach (rcy[i]) if (rcy[i] <= 20) early++;
    checks++; if (early != 2) $display("FAIL ls_reads: got %0d expected 2", early);
    else passes++;
    checks++; if (snap_valid !== 1'b1 || snap_voxel !== 8'h10)
      $display("FAIL ls_hold: got valid %b data %h expected 1 10", snap_valid, snap_voxel);
    else passes++;
    checks++; if (bd.size() != 12) $display("FAIL ls_beat_count: got %0d expected 12", bd.size());
    else passes++;
    for (int i = 0; i < bd.size(); i++) begin
      checks++; if (bd[i] != 16 + i) $display("FAIL ls_data[%0d]: got %0h expected %0h", i, bd[i], 16 + i);
      else passes++;
    end
    checks++; if (bd.size() > 0 && bc[0] != 21) $display("FAIL ls_resume: got %0d expected 21", bc[0]);
    else passes++;
    checks++; if (stab_err != 0 || ovf_err != 0)
      $display("FAIL ls_stable: got %0d/%0d errors expected 0", stab_err, ovf_err);
    else passes++;
  endtask

  task automatic test_start_busy();
    run_cycles(40, 0, 5, -1, -1);
    checks++; if (bd.size() != 12 || dc.size() != 1)
      $display("FAIL sb_ignored: got %0d beats %0d done expected 12 1", bd.size(), dc.size());
    else passes++;
    checks++; if (ra.size() != 12) $display("FAIL sb_reads: got %0d expected 12", ra.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    run_cycles(50, 0, 16, -1, -1);
    checks++; if (bd.size() != 24) $display("FAIL bb_beats: got %0d expected 24", bd.size());
    else passes++;
    checks++; if (ra.size() < 13 || rcy[12] != 17 || ra[12] != 0)
      $display("FAIL bb_second_read: got %0d reads expected addr 0 in cycle 17", ra.size());
    else passes++;
    checks++; if (dc.size() != 2 || dc[1] != 31)
      $display("FAIL bb_done: got %0d pulses expected 2 (second at 31)", dc.size());
    else passes++;
    for (int i = 12; i < bd.size(); i++) begin
      checks++; if (bd[i] != 16 + i - 12) $display("FAIL bb_data[%0d]: got %0h expected %0h", i, bd[i], 4 + i);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int late;
    run_cycles(20, 0, -1, 7, 8);
    checks++; if ({snap_rd, snap_addr, snap_voxel, snap_valid, snap_last, snap_busy, snap_done} !== 17'd0)
      $display("FAIL rm_outputs: got %h expected 0",
               {snap_rd, snap_addr, snap_voxel, snap_valid, snap_last, snap_busy, snap_done});
    else passes++;
    late = 0;
    foreach (bc[i]) if (bc[i] > 7) late++;
    checks++; if (bd.size() != 5 || late != 0)
      $display("FAIL rm_stale: got %0d beats (%0d after reset) expected 5 0", bd.size(), late);
    else passes++;
    checks++; if (dc.size() != 0) $display("FAIL rm_no_done: got %0d expected 0", dc.size());
    else passes++;
    checks++; if (busy_mask[19:8] !== 12'd0) $display("FAIL rm_idle: got %h expected 0", busy_mask[19:8]);
    else passes++;
    run_cycles(40, 0, -1, -1, -1);
    checks++; if (bd.size() != 12 || dc.size() != 1)
      $display("FAIL rm_restart: got %0d beats %0d done expected 12 1", bd.size(), dc.size());
    else passes++;
    for (int i = 0; i < bd.size(); i++) begin
      checks++; if (bd[i] != 16 + i) $display("FAIL rm_data[%0d]: got %0h expected %0h", i, bd[i], 16 + i);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_free_flow();
    test_backpressure();
    test_long_stall();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
